regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug/test sequencer that drives the register file's debug read port (reg_addr in, reg_output back) and streams the selected register contents out over a valid/ready interface.
- Sits beside regfile in the datapath, on the read side of the debug port.
- Used by the test harness and the future debug UART bridge.
- Replaces hand-driven reg_addr probing in benches.

Parameters:
- NUM_REGS, 16, number of architectural registers scanned (R0..R15).
- ADDR_W, 4, width of reg_addr; equals clog2(NUM_REGS).
- DATA_W, 32, width of reg_output and dump_data.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a dump; sampled only in IDLE.
- reg_mask  input  16  bit i=1 selects register Ri; latched when start is accepted.
- busy  output  1  high from start acceptance until done.
- reg_addr  output  ADDR_W  drives the regfile debug address.
- reg_output  input  DATA_W  combinational read data from regfile for reg_addr (R15 returns 11-bit PC zero-extended).
- dump_valid  output  1  beat available.
- dump_ready  input  1  consumer accepts beat.
- dump_data  output  DATA_W  captured register value.
- dump_index  output  5  register number of beat (0..15; 16 = checksum beat, only when the optional feature is compiled in).
- dump_last  output  1  high with the final beat of a dump.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, any state): state=IDLE; busy, dump_valid, dump_last, done=0; reg_addr=0; dump_data=0; dump_index=0; latched mask=0. An in-flight dump is abandoned with no beat and no done.
- FSM states: IDLE, ADDR, HOLD, CSUM (feature only), FIN.
- IDLE:
  - start=1 latches reg_mask and sets busy=1 next cycle.
  - mask==0 goes to FIN with no beats.
  - Otherwise goes to ADDR with reg_addr = lowest set mask bit.
- ADDR (one cycle): regfile read is combinational; at the clock edge capture reg_output into dump_data, reg_addr into dump_index, compute dump_last, then go to HOLD.
- HOLD:
  - dump_valid=1; dump_data, dump_index and dump_last are stable until the handshake.
  - On valid&&ready, clear dump_valid next cycle.
  - If more mask bits are set above the current index: reg_addr=next set bit, go to ADDR.
  - Otherwise go to CSUM (feature) or FIN.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. A start in FIN is ignored.
- Throughput: at most one beat per 2 cycles (ADDR+HOLD). Latency from start acceptance to first dump_valid is 2 cycles.
- start while busy is ignored; the mask is not re-latched.
- dump_ready high while dump_valid=0 has no effect.
- reg_addr holds its last value outside ADDR; it is never driven to unmasked registers during a dump.
- Beat order is strictly ascending register index. Each selected register is emitted exactly once.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - A running 32-bit XOR of every emitted dump_data is cleared at start acceptance.
  - After the last register beat handshakes, CSUM presents one extra beat: dump_index=16, dump_data=XOR, dump_last=1.
  - The last register beat has dump_last=0.
  - mask==0 still produces a CSUM beat with value 0.
- Undefined: no CSUM state and no accumulator. dump_index never exceeds 15. dump_last marks the final register beat.

Decomposition:
- Shared package regdump_pkg:
  - state enum (IDLE, ADDR, HOLD, CSUM, FIN).
  - constants NUM_REGS, ADDR_W, DATA_W.
  - CSUM_INDEX=5'd16.
  - PC_REG=4'd15.
- One sub-module, next_set_bit:
  - Combinational priority finder.
  - Inputs: mask[15:0], cur[3:0], first flag.
  - Outputs: next index and found flag, i.e. the lowest set bit strictly above cur, or the lowest set bit when first=1.

Test Plan:
- Preload R0=0x11, R3=0x33, R15 PC=0x07F; mask=0x8009, dump_ready tied 1 -> beats (0,0x11),(3,0x33),(15,0x0000007F); dump_last only on index 15; done pulse 1 cycle after the last handshake.
- mask=0x0000 -> no dump_valid; busy high 1 cycle; done pulses; checksum build emits a single beat index 16, data 0.
- mask=0xFFFF, dump_ready low for 5 cycles on beat R4=0xDEADBEEF -> dump_data/dump_index stable throughout; R4 then R5 in order; 16 beats total.
- Pulse start again mid-dump with a new mask=0x0001 -> ignored; the original sequence completes unchanged.
- Assert rst during HOLD of beat 2 -> all outputs 0 immediately (async); after release, no done pulse; a new start works from scratch.
- REGDUMP_CHECKSUM_EN defined, mask=0x0006, R1=0xF0F0F0F0, R2=0x0F0F00FF -> third beat index 16, data 0xFFFFF00F, dump_last=1 only on that beat.

Source files
------------

// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and constants for the register-file dump reader.
//   NUM_REGS / ADDR_W / DATA_W : register count, debug address width, data width
//   CSUM_INDEX                 : dump_index value carried by the checksum beat
//   PC_REG                     : register number whose read returns the 11-bit PC
//   state_t                    : dump sequencer states
package regdump_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  localparam logic [4:0]        CSUM_INDEX = 5'd16;
  localparam logic [ADDR_W-1:0] PC_REG     = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    CSUM,
    FIN
  } state_t;

endpackage

// File: rtl/regfile_dump_reader_next_set_bit.sv
// next_set_bit: combinational priority finder over the register mask.
// Ports:
//   mask     in   register select mask (bit i selects Ri)
//   cur      in   index of the register most recently addressed
//   first    in   1: search from bit 0; 0: search strictly above cur
//   next_idx out  lowest qualifying set bit (0 when none)
//   found    out  a qualifying set bit exists
module next_set_bit
  import regdump_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic [ADDR_W-1:0]   cur,
  input  logic                first,
  output logic [ADDR_W-1:0]   next_idx,
  output logic                found
);

  // Scan from the top down so the lowest qualifying bit wins last.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i] && (first || (ADDR_W'(i) > cur))) begin
        next_idx = ADDR_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the regfile debug read port over the registers
// selected by reg_mask and streams their contents out as valid/ready beats
// in ascending register order.
// Optional feature macro: REGDUMP_CHECKSUM_EN -- appends one beat
// (dump_index 16) carrying the XOR of all register beats of the dump.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start         dump request, honoured only in IDLE
//   reg_mask      register select mask, latched on start acceptance
//   busy          dump in progress
//   reg_addr      regfile debug address
//   reg_output    combinational regfile read data for reg_addr
//   dump_valid / dump_ready / dump_data / dump_index / dump_last  beat stream
//   done          one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | reg_addr presented, read data captured at the edge
// HOLD  | register beat offered until handshake
// CSUM  | checksum beat offered until handshake (checksum build only)
// FIN   | final busy cycle; done pulses as it returns to IDLE
module regfile_dump_reader
  import regdump_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic                busy,
  output logic [ADDR_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0]   reg_output,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [DATA_W-1:0]   dump_data,
  output logic [4:0]          dump_index,
  output logic                dump_last,
  output logic                done
);

  state_t              state;
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] nsb_mask;
  logic                nsb_first;
  logic [ADDR_W-1:0]   nsb_next;
  logic                nsb_found;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum;
`endif

  // In IDLE the finder looks at the incoming mask from bit 0; during a dump
  // it looks above the current address in the latched mask.
  assign nsb_first = (state == IDLE);
  assign nsb_mask  = nsb_first ? reg_mask : mask_q;

  next_set_bit u_next_set_bit (
    .mask     (nsb_mask),
    .cur      (reg_addr),
    .first    (nsb_first),
    .next_idx (nsb_next),
    .found    (nsb_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask_q     <= '0;
      busy       <= 1'b0;
      reg_addr   <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_index <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= reg_mask;
            busy   <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            csum   <= '0;
`endif
            if (nsb_found) begin
              reg_addr <= nsb_next;
              state    <= ADDR;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              dump_valid <= 1'b1;
              dump_data  <= '0;
              dump_index <= CSUM_INDEX;
              dump_last  <= 1'b1;
              state      <= CSUM;
`else
              state      <= FIN;
`endif
            end
          end
        end

        ADDR: begin
          dump_data  <= reg_output;
          dump_index <= {1'b0, reg_addr};
`ifdef REGDUMP_CHECKSUM_EN
          dump_last  <= 1'b0;
`else
          dump_last  <= !nsb_found;
`endif
          dump_valid <= 1'b1;
          state      <= HOLD;
        end

        HOLD: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum       <= csum ^ dump_data;
`endif
            if (nsb_found) begin
              reg_addr <= nsb_next;
              state    <= ADDR;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              // Fold in the beat being accepted now; csum lags by one beat.
              dump_valid <= 1'b1;
              dump_data  <= csum ^ dump_data;
              dump_index <= CSUM_INDEX;
              dump_last  <= 1'b1;
              state      <= CSUM;
`else
              state      <= FIN;
`endif
            end
          end
        end

`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            state      <= FIN;
          end
        end
`endif

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  import regdump_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] reg_mask;
  logic        busy;
  logic [3:0]  reg_addr;
  logic [31:0] reg_output;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [4:0]  dump_index;
  logic        dump_last;
  logic        done;

  logic [31:0] regs [16];
  logic [10:0] pc;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q [$];
  beat_t       log_q [$];
  logic [15:0] m_mask = '0;
  bit          m_busy = 1'b0;
  int          cd     = 0;

  regfile_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_mask   (reg_mask),
    .busy       (busy),
    .reg_addr   (reg_addr),
    .reg_output (reg_output),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_index (dump_index),
    .dump_last  (dump_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Regfile debug read port: R15 reads back the PC zero-extended.
  assign reg_output = (reg_addr == PC_REG) ? {21'b0, pc} : regs[reg_addr];

  function automatic logic [31:0] rd(input int i);
    return (i == 15) ? {21'b0, pc} : regs[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Expected beat list for a dump: selected registers ascending, plus the
  // XOR beat when the checksum is built in.
  function automatic void build(input logic [15:0] m);
    logic [31:0] x;
    beat_t       b;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        b.idx  = 5'(i);
        b.data = rd(i);
        b.last = 1'b0;
        exp_q.push_back(b);
        x = x ^ b.data;
      end
    end
`ifdef REGDUMP_CHECKSUM_EN
    b.idx  = 5'd16;
    b.data = x;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endfunction

  // Per-cycle checker: done/busy timing, reg_addr confinement, beat contents.
  always @(negedge clk) begin : monitor
    bit    exp_done;
    beat_t b;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_mask = '0;
      cd     = 0;
    end else begin
      exp_done = (cd == 1);
      if (cd > 0) cd--;
      if (exp_done) m_busy = 1'b0;
      chk("done", done, exp_done);
      chk("busy", busy, m_busy);
      if (m_busy && m_mask != 16'h0) chk("reg_addr_in_mask", m_mask[reg_addr], 1);
      if (dump_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got index %0d data 0x%0h, required no beat", dump_index, dump_data);
        end else begin
          chk("beat_index", dump_index, exp_q[0].idx);
          chk("beat_data", dump_data, exp_q[0].data);
          chk("beat_last", dump_last, exp_q.size() == 1);
          if (dump_ready) begin
            b.idx  = dump_index;
            b.data = dump_data;
            b.last = dump_last;
            log_q.push_back(b);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) cd = 2;
          end
        end
      end
      if (start && !m_busy) begin
        build(reg_mask);
        m_mask = reg_mask;
        m_busy = 1'b1;
        if (exp_q.size() == 0) cd = 2;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] m);
    @(posedge clk); #1;
    start    = 1'b1;
    reg_mask = m;
    @(posedge clk); #1;
    start    = 1'b0;
    reg_mask = 16'hFFFF;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_beat(input logic [4:0] idx, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(dump_valid === 1'b1 && dump_index === idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, (dump_valid === 1'b1 && dump_index === idx), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0101_0101 * i;
    regs[0]  = 32'h0000_0011;
    regs[1]  = 32'hF0F0_F0F0;
    regs[2]  = 32'h0F0F_00FF;
    regs[3]  = 32'h0000_0033;
    regs[4]  = 32'hDEAD_BEEF;
    regs[15] = 32'hFFFF_FFFF;
    pc       = 11'h07F;
    rst        = 1'b1;
    start      = 1'b0;
    reg_mask   = '0;
    dump_ready = 1'b1;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_index", dump_index, 0);
    rst = 1'b0;
    cyc(2);

    // R0, R3, R15 with ready tied high
    log_q.delete();
    do_start(16'h8009);
    chk("t1_valid_addr_cycle", dump_valid, 0);
    cyc(1);
    chk("t1_first_valid", dump_valid, 1);
    chk("t1_first_index", dump_index, 0);
    chk("t1_first_data", dump_data, 32'h11);
    wait_done("t1_done", 50);
    chk("t1_count", log_q.size(), 3 + CS);
    chk("t1_b0_idx", log_q[0].idx, 0);
    chk("t1_b1_data", log_q[1].data, 32'h33);
    chk("t1_b1_last", log_q[1].last, 0);
    chk("t1_b2_idx", log_q[2].idx, 15);
    chk("t1_b2_data", log_q[2].data, 32'h0000_007F);
    chk("t1_b2_last", log_q[2].last, 1 - CS);
    cyc(2);

    // empty mask
    log_q.delete();
    do_start(16'h0000);
    chk("t2_busy", busy, 1);
    chk("t2_valid", dump_valid, CS);
    wait_done("t2_done", 10);
    chk("t2_count", log_q.size(), CS);
`ifdef REGDUMP_CHECKSUM_EN
    chk("t2_cs_idx", log_q[0].idx, 16);
    chk("t2_cs_data", log_q[0].data, 0);
`endif
    cyc(2);

    // full mask with a stall on R4
    log_q.delete();
    do_start(16'hFFFF);
    wait_beat(5'd3, 50, "t3_reach_r3");
    @(posedge clk); #1;
    dump_ready = 1'b0;
    wait_beat(5'd4, 10, "t3_reach_r4");
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_valid", dump_valid, 1);
      chk("t3_stall_data", dump_data, 32'hDEAD_BEEF);
      chk("t3_stall_idx", dump_index, 4);
      @(negedge clk);
    end
    @(posedge clk); #1;
    dump_ready = 1'b1;
    wait_done("t3_done", 100);
    chk("t3_count", log_q.size(), 16 + CS);
    for (int i = 0; i < 16; i++) chk("t3_order", log_q[i].idx, i);
    chk("t3_r4", log_q[4].data, 32'hDEAD_BEEF);
    chk("t3_r5", log_q[5].data, 32'h0505_0505);
    cyc(2);

    // start pulse mid-dump is ignored
    log_q.delete();
    do_start(16'h00A4);
    cyc(1);
    do_start(16'h0001);
    wait_done("t4_done", 50);
    chk("t4_count", log_q.size(), 3 + CS);
    chk("t4_b0", log_q[0].idx, 2);
    chk("t4_b1", log_q[1].idx, 5);
    chk("t4_b2", log_q[2].idx, 7);
    cyc(3);

    // async reset during HOLD of the second beat
    log_q.delete();
    do_start(16'h0007);
    wait_beat(5'd0, 10, "t5_reach_b0");
    @(posedge clk); #1;
    dump_ready = 1'b0;
    wait_beat(5'd1, 10, "t5_reach_b1");
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", dump_valid, 0);
    chk("t5_last", dump_last, 0);
    chk("t5_done", done, 0);
    chk("t5_addr", reg_addr, 0);
    chk("t5_data", dump_data, 0);
    chk("t5_index", dump_index, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4);
    dump_ready = 1'b1;
    log_q.delete();
    do_start(16'h0010);
    wait_done("t5_restart_done", 20);
    chk("t5_restart_count", log_q.size(), 1 + CS);
    chk("t5_restart_idx", log_q[0].idx, 4);
    chk("t5_restart_data", log_q[0].data, 32'hDEAD_BEEF);
    cyc(2);

    // R1, R2 (checksum 0xFFFFF00F when built in)
    log_q.delete();
    do_start(16'h0006);
    wait_done("t6_done", 20);
    chk("t6_count", log_q.size(), 2 + CS);
    chk("t6_b0_data", log_q[0].data, 32'hF0F0_F0F0);
    chk("t6_b1_data", log_q[1].data, 32'h0F0F_00FF);
    chk("t6_b1_last", log_q[1].last, 1 - CS);
`ifdef REGDUMP_CHECKSUM_EN
    chk("t6_cs_idx", log_q[2].idx, 16);
    chk("t6_cs_data", log_q[2].data, 32'hFFFF_F00F);
    chk("t6_cs_last", log_q[2].last, 1);
`endif
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
